// File: rtl/issue_unit_if.sv
// Issue handshake bundle between the four execution queues and the issue arbiter.
// The CDB reservation vector is exported as [DIV_LAT-2:0]; bit k-1 means the CDB is taken k cycles ahead.
interface issue_unit_if #(
    parameter int unsigned DIV_LAT = 7
);
    logic                 issueint_ready;
    logic                 issueint_done;
    logic                 issuemul_ready;
    logic                 issuemul_done;
    logic                 issuediv_ready;
    logic                 issuediv_done;
    logic                 issueldst_ready;
    logic                 issueldst_done;
    logic [DIV_LAT-2:0]   issue_cdb_slot;
    logic                 issue_div_busy;

    // Queue side: raises ready, sees grants and reservation status.
    modport master (
        output issueint_ready,
        output issuemul_ready,
        output issuediv_ready,
        output issueldst_ready,
        input  issueint_done,
        input  issuemul_done,
        input  issuediv_done,
        input  issueldst_done,
        input  issue_cdb_slot,
        input  issue_div_busy
    );

    // Arbiter side.
    modport slave (
        input  issueint_ready,
        input  issuemul_ready,
        input  issuediv_ready,
        input  issueldst_ready,
        output issueint_done,
        output issuemul_done,
        output issuediv_done,
        output issueldst_done,
        output issue_cdb_slot,
        output issue_div_busy
    );
endinterface

// File: rtl/issue_unit.sv
// Central issue arbiter: at most one grant per cycle (div > mul > int/ldst round-robin),
// reserving the single CDB slot the granted instruction will write and tracking the divider.
module issue_unit #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 7
) (
    input  logic          clk,
    input  logic          reset,
    issue_unit_if.slave   issue_bus
);
    localparam int unsigned CNT_W = $clog2(DIV_LAT);

    typedef enum logic {
        PREF_INT  = 1'b0,
        PREF_LDST = 1'b1
    } lru_e;

    logic [DIV_LAT-1:1] r_slot;
    logic [CNT_W-1:0]   r_div_cnt;
    lru_e               r_lru;

    logic               w_div_elig;
    logic               w_mul_elig;
    logic               w_int_elig;
    logic               w_ldst_elig;

    logic               w_div_grant;
    logic               w_mul_grant;
    logic               w_int_grant;
    logic               w_ldst_grant;

    logic [DIV_LAT-1:1] w_slot_next;
    logic [CNT_W-1:0]   w_div_cnt_next;
    lru_e               w_lru_next;

    // A div result lands DIV_LAT cycles out, beyond every stored slot, so it never collides.
    assign w_div_elig  = issue_bus.issuediv_ready  & (r_div_cnt == '0);
    assign w_mul_elig  = issue_bus.issuemul_ready  & ~r_slot[MUL_LAT];
    assign w_int_elig  = issue_bus.issueint_ready  & ~r_slot[1];
    assign w_ldst_elig = issue_bus.issueldst_ready & ~r_slot[1];

    always_comb begin
        w_div_grant  = 1'b0;
        w_mul_grant  = 1'b0;
        w_int_grant  = 1'b0;
        w_ldst_grant = 1'b0;
        if (!reset) begin
            if (w_div_elig) begin
                w_div_grant = 1'b1;
            end else if (w_mul_elig) begin
                w_mul_grant = 1'b1;
            end else if (w_int_elig && w_ldst_elig) begin
                if (r_lru == PREF_INT) begin
                    w_int_grant = 1'b1;
                end else begin
                    w_ldst_grant = 1'b1;
                end
            end else if (w_int_elig) begin
                w_int_grant = 1'b1;
            end else if (w_ldst_elig) begin
                w_ldst_grant = 1'b1;
            end
        end
    end

    // Latency-1 grants use the CDB on the next edge, which was already checked free, so nothing is stored.
    always_comb begin
        w_slot_next                = {1'b0, r_slot[DIV_LAT-1:2]};
        w_slot_next[DIV_LAT-1]     = w_div_grant;
        w_slot_next[MUL_LAT-1]     = w_slot_next[MUL_LAT-1] | w_mul_grant;
    end

    always_comb begin
        w_div_cnt_next = r_div_cnt;
        if (w_div_grant) begin
            w_div_cnt_next = CNT_W'(DIV_LAT - 1);
        end else if (r_div_cnt != '0) begin
            w_div_cnt_next = r_div_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        w_lru_next = r_lru;
        if (w_int_grant) begin
            w_lru_next = PREF_LDST;
        end else if (w_ldst_grant) begin
            w_lru_next = PREF_INT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot    <= '0;
            r_div_cnt <= '0;
            r_lru     <= PREF_INT;
        end else begin
            r_slot    <= w_slot_next;
            r_div_cnt <= w_div_cnt_next;
            r_lru     <= w_lru_next;
        end
    end

    assign issue_bus.issuediv_done  = w_div_grant;
    assign issue_bus.issuemul_done  = w_mul_grant;
    assign issue_bus.issueint_done  = w_int_grant;
    assign issue_bus.issueldst_done = w_ldst_grant;
    assign issue_bus.issue_cdb_slot = r_slot;
    assign issue_bus.issue_div_busy = (r_div_cnt != '0);

endmodule
